// File: rtl/alu_unit.sv
// alu_unit: registered integer ALU with zero/negative/carry/overflow flags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            capture a/b/alu_ctrl on the rising edge when high
//   a, b                operands (b[SHW-1:0] is the shift amount for shifts)
//   alu_ctrl            opcode: ADD SUB AND OR SLL SRL XOR SLT
//   out_valid           result/flags were computed on the previous edge
//   result, Z, N, C, O  registered result and flags
module alu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             O
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;
  logic             add_ovf;
  logic             lt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;

  // Shared adder: SUB is a + ~b + 1, so carry-out = 1 means no borrow.
  assign is_sub  = (alu_ctrl == OP_SUB);
  assign b_op    = is_sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_op} + (WIDTH + 1)'(is_sub);
  // Overflow when the effective addends agree in sign but the sum does not.
  assign add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign lt      = ($signed(a) < $signed(b));
  assign shamt   = b[SHW-1:0];

  // Result and arithmetic flag selection.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    unique case (alu_ctrl)
      OP_ADD, OP_SUB: begin
        res_c   = sum_ext[WIDTH-1:0];
        carry_c = sum_ext[WIDTH];
        ovf_c   = add_ovf;
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_SLL:  res_c = a << shamt;
      OP_SRL:  res_c = a >> shamt;
      OP_XOR:  res_c = a ^ b;
      OP_SLT:  res_c = {{(WIDTH - 1){1'b0}}, lt};
      default: res_c = '0;
    endcase
  end

  // Output registers; hold on in_valid = 0, all zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      C         <= 1'b0;
      O         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= res_c;
        Z      <= (res_c == '0);
        N      <= res_c[WIDTH-1];
        C      <= carry_c;
        O      <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector self-checking bench for alu_unit.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctrl;
  logic        out_valid;
  logic [31:0] result;
  logic        Z, N, C, O;

  int total;
  int bad;

  alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .alu_ctrl(alu_ctrl), .out_valid(out_valid), .result(result),
    .Z(Z), .N(N), .C(C), .O(O)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, Z, N, C, O};
  endfunction

  // Drive one valid op at the falling edge, check one cycle later.
  task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    alu_ctrl = op;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, er);
    check({tag, ".zncо"}, flags(), {28'd0, ef});
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    alu_ctrl = 3'b000;
    total    = 0;
    bad      = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.result", result, 32'd0);
    check("reset.flags", flags(), 32'd0);
    check("reset.valid", {31'd0, out_valid}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle.valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back vectors; flags are {Z,N,C,O}.
    run_vec("add_basic", 3'b000, 32'd10, 32'd20, 32'd30, 4'b0000);
    run_vec("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101);
    run_vec("add_carry", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1010);
    run_vec("sub_basic", 3'b001, 32'd50, 32'd20, 32'd30, 4'b0010);
    run_vec("sub_ovf", 3'b001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011);
    run_vec("sub_zero", 3'b001, 32'd5, 32'd5, 32'd0, 4'b1010);
    run_vec("sub_borrow", 3'b001, 32'd1, 32'd2, 32'hFFFF_FFFF, 4'b0100);
    run_vec("and", 3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0000);
    run_vec("or", 3'b011, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 4'b0000);
    run_vec("xor", 3'b110, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'b0000);
    run_vec("sll", 3'b100, 32'd1, 32'd4, 32'd16, 4'b0000);
    run_vec("srl", 3'b101, 32'd32, 32'd2, 32'd8, 4'b0000);
    run_vec("sll_upper_b", 3'b100, 32'd1, 32'h24, 32'd16, 4'b0000);
    run_vec("sll_zero", 3'b100, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 4'b0100);
    run_vec("srl_msb", 3'b101, 32'h8000_0000, 32'd31, 32'd1, 4'b0000);
    run_vec("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000);
    run_vec("slt_false", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1000);
    run_vec("xor_neg", 3'b110, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000, 4'b0100);

    // in_valid low for two cycles with changing inputs: outputs hold.
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = 3'b000;
    a        = 32'd7;
    b        = 32'd9;
    @(posedge clk);
    #1;
    check("hold1.valid", {31'd0, out_valid}, 32'd0);
    check("hold1.result", result, 32'hFFFF_0000);
    @(negedge clk);
    alu_ctrl = 3'b001;
    @(posedge clk);
    #1;
    check("hold2.valid", {31'd0, out_valid}, 32'd0);
    check("hold2.result", result, 32'hFFFF_0000);
    check("hold2.flags", flags(), 32'h4);

    // Async reset mid-stream discards the in-flight op.
    run_vec("pre_rst", 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd3;
    b        = 32'd4;
    alu_ctrl = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.result", result, 32'd0);
    check("async_rst.flags", flags(), 32'd0);
    check("async_rst.valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("in_rst.valid", {31'd0, out_valid}, 32'd0);
    check("in_rst.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_rst.result", result, 32'd7);
    check("first_after_rst.valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_rst.valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
